// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: MEM_LEN codes, FSM encodings, alignment check.
// MEM_UNALIGNED_EN enables LWL/LWR/SWL/SWR; when undefined, WL/WR behave as W.
package mem_access_unit_pkg;

  localparam int MEM_LEN_W = 3;

  localparam logic [MEM_LEN_W-1:0] MEM_LEN_B  = 3'd0;
  localparam logic [MEM_LEN_W-1:0] MEM_LEN_H  = 3'd1;
  localparam logic [MEM_LEN_W-1:0] MEM_LEN_W4 = 3'd2;
  localparam logic [MEM_LEN_W-1:0] MEM_LEN_WL = 3'd3;
  localparam logic [MEM_LEN_W-1:0] MEM_LEN_WR = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic addr_misaligned(input logic [MEM_LEN_W-1:0] len, input logic [1:0] o);
    logic bad;
    bad = 1'b0;
    case (len)
      MEM_LEN_H:  bad = o[0];
      MEM_LEN_W4: bad = (o != 2'b00);
`ifndef MEM_UNALIGNED_EN
      MEM_LEN_WL, MEM_LEN_WR: bad = (o != 2'b00);
`endif
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_format.sv
// Combinational lane logic: byte enables / store data shifting and load result formatting.
// MEM_UNALIGNED_EN compiles in the WL/WR merge paths; otherwise WL/WR fall through to W.
module mem_lane_format
  import mem_access_unit_pkg::*;
(
  input  logic [MEM_LEN_W-1:0] len,
  input  logic [1:0]           o,
  input  logic [31:0]          wdata,
  input  logic                 sign_ext,
  input  logic [31:0]          word,
  input  logic [31:0]          rtold,
  output logic [3:0]           be,
  output logic [31:0]          bus_wdata,
  output logic [31:0]          rdata
);

  logic [4:0]  sh;
  logic [31:0] word_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign sh      = {o, 3'b000};
  assign word_sh = word >> sh;
  assign byte_v  = word_sh[7:0];
  assign half_v  = o[1] ? word[31:16] : word[15:0];

`ifdef MEM_UNALIGNED_EN
  // 8*(3-o): for a 2-bit offset, 3-o is simply ~o.
  logic [4:0] shl;
  assign shl = {~o, 3'b000};
`else
  logic unused_rtold;
  assign unused_rtold = ^rtold;
`endif

  always_comb begin
    be        = 4'b1111;
    bus_wdata = wdata;
    rdata     = word;
    case (len)
      MEM_LEN_B: begin
        be        = 4'b0001 << o;
        bus_wdata = {4{wdata[7:0]}};
        rdata     = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      MEM_LEN_H: begin
        be        = o[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{wdata[15:0]}};
        rdata     = {{16{sign_ext & half_v[15]}}, half_v};
      end
`ifdef MEM_UNALIGNED_EN
      MEM_LEN_WL: begin
        be        = 4'b1111 >> ~o;
        bus_wdata = wdata >> shl;
        rdata     = (word << shl) | (rtold & ~(32'hFFFF_FFFF << shl));
      end
      MEM_LEN_WR: begin
        be        = 4'b1111 << o;
        bus_wdata = wdata << sh;
        rdata     = (word >> sh) | (rtold & ~(32'hFFFF_FFFF >> sh));
      end
`endif
      default: begin
        be        = 4'b1111;
        bus_wdata = wdata;
        rdata     = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one request/ack data-bus transaction per request, with address-error
// detection and optional bus timeout. MEM_UNALIGNED_EN enables LWL/LWR/SWL/SWR.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int BUS_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [MEM_LEN_W-1:0] req_len,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [31:0]          req_rtold,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_adel,
  output logic                 resp_ades,
  output logic                 resp_buserr,
  output logic [31:0]          resp_badvaddr,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [31:0]          bus_addr,
  output logic [3:0]           bus_be,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_ack,
  input  logic [31:0]          bus_rdata
);

  localparam logic [31:0] TMO_LAST = 32'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  logic [1:0]           state_q, state_d;
  logic [MEM_LEN_W-1:0] len_q, len_d;
  logic                 sgn_q, sgn_d, rd_q, rd_d, we_q, we_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rtold_q, rtold_d, word_q, word_d;
  logic                 adel_q, adel_d, ades_q, ades_d, buserr_q, buserr_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 bus_req_q, bus_req_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d, resp_badvaddr_q, resp_badvaddr_d;
  logic                 resp_adel_q, resp_adel_d, resp_ades_q, resp_ades_d;
  logic                 resp_buserr_q, resp_buserr_d;

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_rdata;

  mem_lane_format u_fmt (
    .len       (len_q),
    .o         (addr_q[1:0]),
    .wdata     (wdata_q),
    .sign_ext  (sgn_q),
    .word      (word_q),
    .rtold     (rtold_q),
    .be        (fmt_be),
    .bus_wdata (fmt_wdata),
    .rdata     (fmt_rdata)
  );

  // The response registers fill during RESP, so the pulse lands the cycle after; hold off
  // new requests until that pulse has been seen.
  assign req_ready     = (state_q == ST_IDLE) && !resp_valid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_adel     = resp_adel_q;
  assign resp_ades     = resp_ades_q;
  assign resp_buserr   = resp_buserr_q;
  assign resp_badvaddr = resp_badvaddr_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_req_q & we_q;
  assign bus_addr      = bus_req_q ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be        = bus_req_q ? fmt_be : 4'd0;
  assign bus_wdata     = (bus_req_q & we_q) ? fmt_wdata : 32'd0;

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    sgn_d           = sgn_q;
    rd_d            = rd_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rtold_d         = rtold_q;
    word_d          = word_q;
    adel_d          = adel_q;
    ades_d          = ades_q;
    buserr_d        = buserr_q;
    cnt_d           = cnt_q;
    bus_req_d       = bus_req_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    resp_adel_d     = resp_adel_q;
    resp_ades_d     = resp_ades_q;
    resp_buserr_d   = resp_buserr_q;
    resp_badvaddr_d = resp_badvaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          len_d    = req_len;
          sgn_d    = req_signed;
          rd_d     = req_read;
          we_d     = req_write & ~req_read;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rtold_d  = req_rtold;
          word_d   = 32'd0;
          adel_d   = 1'b0;
          ades_d   = 1'b0;
          buserr_d = 1'b0;
          cnt_d    = 32'd0;
          if (!req_read && !req_write) begin
            state_d = ST_RESP;
          end else if (addr_misaligned(req_len, req_addr[1:0])) begin
            adel_d  = req_read;
            ades_d  = ~req_read;
            state_d = ST_RESP;
          end else begin
            bus_req_d = 1'b1;
            state_d   = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          word_d    = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (BUS_TIMEOUT > 0 && cnt_q == TMO_LAST) begin
          buserr_d  = 1'b1;
          bus_req_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RESP: begin
        resp_valid_d    = 1'b1;
        resp_rdata_d    = (rd_q && !adel_q && !buserr_q) ? fmt_rdata : 32'd0;
        resp_adel_d     = adel_q;
        resp_ades_d     = ades_q;
        resp_buserr_d   = buserr_q;
        resp_badvaddr_d = (adel_q || ades_q || buserr_q) ? addr_q : 32'd0;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      len_q           <= '0;
      sgn_q           <= 1'b0;
      rd_q            <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rtold_q         <= '0;
      word_q          <= '0;
      adel_q          <= 1'b0;
      ades_q          <= 1'b0;
      buserr_q        <= 1'b0;
      cnt_q           <= '0;
      bus_req_q       <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_adel_q     <= 1'b0;
      resp_ades_q     <= 1'b0;
      resp_buserr_q   <= 1'b0;
      resp_badvaddr_q <= '0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      sgn_q           <= sgn_d;
      rd_q            <= rd_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rtold_q         <= rtold_d;
      word_q          <= word_d;
      adel_q          <= adel_d;
      ades_q          <= ades_d;
      buserr_q        <= buserr_d;
      cnt_q           <= cnt_d;
      bus_req_q       <= bus_req_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_adel_q     <= resp_adel_d;
      resp_ades_q     <= resp_ades_d;
      resp_buserr_q   <= resp_buserr_d;
      resp_badvaddr_q <= resp_badvaddr_d;
    end
  end

endmodule
